// File: rtl/tile_scan_fetch.sv
// Raster-to-tile address generator: turns VGA position plus camera scroll into level-map,
// tile-ROM addresses and a registered colour/valid/opacity stream for the compositor.
module tile_scan_fetch #(
    parameter int          MAP_COLS    = 224,
    parameter int          MAP_ROWS    = 24,
    parameter int          MAP_AW      = 13,
    parameter logic [23:0] TRANSPARENT = 24'h800080
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_en,
    input  logic [7:0]        scroll_tile,
    input  logic [4:0]        scroll_fine,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [3:0]        map_data,
    output logic [3:0]        tile_sel,
    output logic [8:0]        read_address,
    input  logic [23:0]       tile_color,
    output logic [23:0]       color_out,
    output logic [3:0]        tile_id_out,
    output logic              opaque_out,
    output logic              out_valid
);

    localparam logic [4:0]        OFF_LAST   = 5'd19;
    localparam logic [7:0]        COL_LAST   = 8'(MAP_COLS - 1);
    localparam logic [MAP_AW-1:0] ROW_STRIDE = MAP_AW'(MAP_COLS);
    localparam logic [5:0]        ROW_LIMIT  = 6'(MAP_ROWS);

    logic [7:0]        scroll_tile_r;
    logic [4:0]        scroll_fine_r;
    logic              lock_r;
    logic [7:0]        col_r;
    logic [4:0]        offx_r;
    logic [4:0]        offy_r;
    logic [4:0]        row_r;
    logic [MAP_AW-1:0] row_base_r;

    logic              frame_start_s;
    logic              lock_next_s;
    logic [7:0]        scroll_tile_s;
    logic [4:0]        scroll_fine_s;
    logic [7:0]        col_s;
    logic [4:0]        offx_s;
    logic [4:0]        offy_s;
    logic [4:0]        row_s;
    logic [MAP_AW-1:0] row_base_s;
    logic              oob_s;
    logic [8:0]        pix_addr_s;
    logic [MAP_AW-1:0] map_idx_s;
    logic              opaque_s;

    logic [8:0]        pix_addr_s1_r;
    logic              oob_s1_r;
    logic              v1_r;
    logic              v2_r;

    // Frame-start detection and the scroll values that apply to the current pixel
    always_comb begin
        frame_start_s = pix_en && (DrawX == 10'd0) && (DrawY == 10'd0);
        lock_next_s   = lock_r || frame_start_s;
        if (frame_start_s) begin
            scroll_tile_s = scroll_tile;
            scroll_fine_s = scroll_fine;
        end else begin
            scroll_tile_s = scroll_tile_r;
            scroll_fine_s = scroll_fine_r;
        end
    end

    // Horizontal tile/offset for the current pixel, stepped from the previous pixel
    always_comb begin
        if (DrawX == 10'd0) begin
            col_s  = scroll_tile_s;
            offx_s = scroll_fine_s;
        end else if (offx_r >= OFF_LAST) begin
            offx_s = 5'd0;
            if (col_r == COL_LAST) begin
                col_s = 8'd0;
            end else begin
                col_s = col_r + 8'd1;
            end
        end else begin
            offx_s = offx_r + 5'd1;
            col_s  = col_r;
        end
    end

    // Vertical tile/offset: only a line-start pixel moves it, and it uses the new value
    always_comb begin
        if (DrawX != 10'd0) begin
            offy_s     = offy_r;
            row_s      = row_r;
            row_base_s = row_base_r;
        end else if (DrawY == 10'd0) begin
            offy_s     = 5'd0;
            row_s      = 5'd0;
            row_base_s = '0;
        end else if (offy_r >= OFF_LAST) begin
            offy_s     = 5'd0;
            row_s      = row_r + 5'd1;
            row_base_s = row_base_r + ROW_STRIDE;
        end else begin
            offy_s     = offy_r + 5'd1;
            row_s      = row_r;
            row_base_s = row_base_r;
        end
    end

    // Address arithmetic: offy*20 as shift-add, rows below the map read tile 0
    always_comb begin
        oob_s      = ({1'b0, row_s} >= ROW_LIMIT);
        pix_addr_s = {offy_s, 4'b0000} + {2'b00, offy_s, 2'b00} + {4'b0000, offx_s};
        if (oob_s) begin
            map_idx_s = '0;
        end else begin
            map_idx_s = row_base_s + {{(MAP_AW-8){1'b0}}, col_s};
        end
        opaque_s = v2_r && (tile_sel != 4'd0) && (tile_color != TRANSPARENT);
    end

    // Scroll latch, frame lock and the raster counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scroll_tile_r <= 8'd0;
            scroll_fine_r <= 5'd0;
            lock_r        <= 1'b0;
            col_r         <= 8'd0;
            offx_r        <= 5'd0;
            offy_r        <= 5'd0;
            row_r         <= 5'd0;
            row_base_r    <= '0;
        end else begin
            if (frame_start_s) begin
                scroll_tile_r <= scroll_tile;
                scroll_fine_r <= scroll_fine;
                lock_r        <= 1'b1;
            end
            if (pix_en) begin
                col_r      <= col_s;
                offx_r     <= offx_s;
                offy_r     <= offy_s;
                row_r      <= row_s;
                row_base_r <= row_base_s;
            end
        end
    end

    // Stage 1: level-map address out, tile-local pixel address held for stage 2
    always_ff @(posedge Clk) begin
        if (Reset) begin
            map_addr      <= '0;
            pix_addr_s1_r <= 9'd0;
            oob_s1_r      <= 1'b0;
            v1_r          <= 1'b0;
        end else begin
            v1_r <= pix_en && lock_next_s;
            if (pix_en) begin
                map_addr      <= map_idx_s;
                pix_addr_s1_r <= pix_addr_s;
                oob_s1_r      <= oob_s;
            end
        end
    end

    // Stage 2: tile id from the map RAM selects the ROM; pixel address presented
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tile_sel     <= 4'd0;
            read_address <= 9'd0;
            v2_r         <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                tile_sel     <= oob_s1_r ? 4'd0 : map_data;
                read_address <= pix_addr_s1_r;
            end
        end
    end

    // Stage 3: register ROM colour with its tile id, opacity and valid
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_out   <= 24'd0;
            tile_id_out <= 4'd0;
            opaque_out  <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid  <= v2_r;
            opaque_out <= opaque_s;
            if (v2_r) begin
                color_out   <= tile_color;
                tile_id_out <= tile_sel;
            end
        end
    end

endmodule

// File: doc/tile_scan_fetch.md
Name: tile_scan_fetch

Overview:
Upstream address generator for the 20x20 tile-sprite ROMs (4-bit palette index, 9-bit read address, combinational 24-bit colour out). It converts the VGA raster position plus the camera scroll into a level-map lookup, a tile select and a per-pixel ROM address. It then registers the returned colour with valid and opacity flags for the layer compositor. Horizontal and vertical tile/offset tracking uses incremental counters: no divider, no multiplier.

Parameters:
MAP_COLS, 224, level width in tiles
MAP_ROWS, 24, level height in tiles (480 lines / 20)
MAP_AW, 13, level-map address width (ceil(log2(MAP_COLS*MAP_ROWS)))
TRANSPARENT, 24'h800080, colour key treated as see-through

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column from VGA controller
DrawY  in  10  current pixel row from VGA controller
pix_en  in  1  DrawX/DrawY is an active-area pixel this cycle
scroll_tile  in  8  camera left edge, whole tiles
scroll_fine  in  5  camera left edge, pixel offset within tile (0..19)
map_addr  out  MAP_AW  level-map RAM address (RAM read latency exactly 1 cycle)
map_data  in  4  tile id returned by level-map RAM; 0 = empty/sky
tile_sel  out  4  tile id presented to external ROM mux
read_address  out  9  pixel address into selected 20x20 tile ROM
tile_color  in  24  combinational colour from selected ROM
color_out  out  24  registered pixel colour
tile_id_out  out  4  tile id of color_out
opaque_out  out  1  color_out is drawable (non-empty tile, not TRANSPARENT)
out_valid  out  1  color_out/tile_id_out/opaque_out valid this cycle

Behaviour:
- Reset: every output and internal register is 0, including out_valid, opaque_out, map_addr, read_address, tile_sel, color_out, tile_id_out, and the counters, locks and latched scroll.
- Scroll latch: scroll_tile/scroll_fine are sampled only on a pix_en cycle with DrawX==0 && DrawY==0 (frame start). They are held for the whole frame; mid-frame changes have no effect.
- Frame lock: after reset, out_valid stays 0 until the first frame-start pixel. A frame-start pixel sets lock. Reset clears lock.
- Horizontal counters (col 8b, offx 5b), evaluated for each pix_en pixel:
  - DrawX==0: col = latched scroll_tile, offx = latched scroll_fine. At frame start, use the values being latched that cycle.
  - Otherwise: offx+1. On wrap 19->0, col+1. col == MAP_COLS-1 incrementing wraps to 0.
- Vertical counters (offy 5b, row 5b, row_base MAP_AW), updated on pix_en && DrawX==0 pixels:
  - DrawY==0: offy=0, row=0, row_base=0.
  - Otherwise: offy+1. On wrap 19->0, row+1 and row_base += MAP_COLS.
  - The values used for the DrawX==0 pixel are the updated ones.
- Cycles with pix_en=0 do not advance any counter.
- Pipeline, latency 3 cycles from pix_en input to out_valid:
  - S1 (edge after input): map_addr <= row_base + col; pix_addr_s1 <= offy*20 + offx, formed as (offy<<4)+(offy<<2)+offx with range 0..399; v1 <= pix_en && lock_next.
  - S2: tile_sel <= map_data (forced 0 if row >= MAP_ROWS; map_addr also forced 0 in that case at S1); read_address <= pix_addr_s1; v2 <= v1.
  - S3: color_out <= tile_color; tile_id_out <= tile_sel; opaque_out <= v2 && tile_sel!=0 && tile_color!=TRANSPARENT; out_valid <= v2.
- map_addr, tile_sel and read_address hold their last values when no pixel is in the stage. color_out and tile_id_out hold when out_valid=0, and opaque_out is 0 when out_valid=0.
- Back-to-back pixels are fully pipelined: one result per cycle, no stalls, no backpressure.
- Reset asserted mid-line: all pipeline valids are cleared that edge, so in-flight pixels are dropped. Output resumes 3 cycles after the next frame-start pixel.
- Simultaneous frame start and scroll change: the new scroll applies to that pixel.

Test Plan:
1. Reset, then a frame with scroll 0/0 and pixel (0,0) -> 3 cycles later out_valid=1; map_addr was 0 and read_address 0; map_data=1, tile_color=24'hE6570C -> color_out=E6570C, opaque_out=1.
2. Same line, DrawX=19 -> read_address 19, map_addr 0. DrawX=20 -> map_addr 1, read_address 0. Feed pixels back-to-back and check one out_valid per cycle.
3. DrawY=21, DrawX=0 -> offy=1: read_address 20, map_addr 224. DrawY=479, DrawX=399 -> read_address 399, map_addr 23*224+19=5171.
4. Frame start with scroll_tile=3, scroll_fine=5 -> DrawX=0 gives map_addr 3, read_address 5. DrawX=15 gives map_addr 4, read_address 0. Change scroll mid-frame -> DrawX=0 of the next line still gives map_addr base col 3.
5. tile_color=24'h800080 with map_data=2 -> opaque_out=0, out_valid=1. map_data=0 with any colour -> opaque_out=0, tile_id_out=0.
6. Assert Reset for one cycle mid-line, with 3 pixels in flight -> out_valid=0 for them. Pixels with DrawY!=0 keep out_valid=0, and the first valid output is frame start +3 cycles. Insert pix_en=0 gaps and check that offx does not advance.
